// File: rtl/temp_pkg.sv
// Shared constants and FSM state type for the temperature threshold monitor.
package temp_pkg;

  localparam int DATA_W = 10;
  localparam int DROP_W = 8;

  localparam logic [DATA_W-1:0] TH_HIGH_DEF = 10'd37;
  localparam logic [DATA_W-1:0] TH_LOW_DEF  = 10'd33;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    AVG   = 2'd1,
    CMP   = 2'd2
  } state_t;

endpackage

// File: rtl/temp_threshold_monitor_if.sv
// Sample handshake and result bundle between the ADC side (master) and the monitor (slave).
interface temp_threshold_monitor_if
  import temp_pkg::*;
#(
  parameter int DW = DATA_W
) ();

  logic [DW-1:0]     sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic [DW-1:0]     avg_out;
  logic              avg_valid;
  logic              alarm;
  logic              alarm_rise;
  logic [DROP_W-1:0] drop_cnt;
  logic              alarm_clr;

  modport master (
    output sample_in, sample_valid, alarm_clr,
    input  sample_ready, avg_out, avg_valid, alarm, alarm_rise, drop_cnt
  );

  modport slave (
    input  sample_in, sample_valid, alarm_clr,
    output sample_ready, avg_out, avg_valid, alarm, alarm_rise, drop_cnt
  );

endinterface

// File: rtl/sample_averager.sv
// Block accumulator: sums 2**AVG_LOG2 accepted samples and publishes the truncated mean.
module sample_averager #(
  parameter int DATA_W   = 10,
  parameter int AVG_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rstc,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_xfer,
  output logic              o_blk_done,
  output logic [DATA_W-1:0] o_avg,
  output logic              o_avg_valid
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_avg;
  logic              r_avg_valid;
  logic [ACC_W-1:0]  w_sum;
  logic              w_last;

  // The final sum of a full all-ones block still fits in ACC_W bits.
  assign w_sum       = r_acc + ACC_W'(i_sample);
  assign w_last      = (r_cnt == LAST_IDX);
  assign o_blk_done  = i_xfer & w_last;
  assign o_avg       = r_avg;
  assign o_avg_valid = r_avg_valid;

  always_ff @(posedge clk) begin
    if (rstc) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      if (i_xfer) begin
        if (w_last) begin
          r_acc       <= '0;
          r_cnt       <= '0;
          r_avg       <= DATA_W'(w_sum >> AVG_LOG2);
          r_avg_valid <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/temp_threshold_monitor.sv
// Averages ADC temperature samples and drives a hysteretic over-temperature alarm.
// Define TEMP_ALARM_LATCH_EN to make the alarm sticky until alarm_clr.
module temp_threshold_monitor
  import temp_pkg::*;
#(
  parameter int                DATA_W   = temp_pkg::DATA_W,
  parameter int                AVG_LOG2 = 3,
  parameter logic [DATA_W-1:0] TH_HIGH  = TH_HIGH_DEF,
  parameter logic [DATA_W-1:0] TH_LOW   = TH_LOW_DEF
) (
  input logic                     clk,
  input logic                     rstc,
  temp_threshold_monitor_if.slave bus
);

  if (TH_LOW > TH_HIGH || AVG_LOG2 < 0 || AVG_LOG2 > 6) begin : g_bad_cfg
    $error("temp_threshold_monitor: need TH_LOW <= TH_HIGH and 0 <= AVG_LOG2 <= 6");
  end

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ready;
  logic                r_alarm;
  logic                r_alarm_rise;
  logic [DROP_W-1:0]   r_drop;
  logic                w_xfer;
  logic                w_blk_done;
  logic                w_set;
  logic                w_clr;
  logic [DATA_W-1:0]   w_avg;
  logic                w_avg_valid;

  assign w_xfer = bus.sample_valid & r_ready;

  sample_averager #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_averager (
    .clk         (clk),
    .rstc        (rstc),
    .i_sample    (bus.sample_in),
    .i_xfer      (w_xfer),
    .o_blk_done  (w_blk_done),
    .o_avg       (w_avg),
    .o_avg_valid (w_avg_valid)
  );

  // Next state plus alarm set/clear decisions; the compare result lands while in CMP.
  always_comb begin
    w_state_nxt = r_state;
    w_set       = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ACCUM: begin
        if (w_blk_done) begin
          w_state_nxt = AVG;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      AVG: begin
        w_state_nxt = CMP;
        w_set       = !r_alarm && (w_avg > TH_HIGH);
`ifndef TEMP_ALARM_LATCH_EN
        w_clr       = r_alarm && (w_avg < TH_LOW);
`endif
      end
      CMP:     w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
`ifdef TEMP_ALARM_LATCH_EN
    w_clr = bus.alarm_clr;
`endif
  end

  always_ff @(posedge clk) begin
    if (rstc) begin
      r_state      <= ACCUM;
      r_ready      <= 1'b1;
      r_alarm      <= 1'b0;
      r_alarm_rise <= 1'b0;
      r_drop       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ready      <= (w_state_nxt == ACCUM);
      r_alarm_rise <= w_set;
      if (w_set) begin
        r_alarm <= 1'b1;
      end else if (w_clr) begin
        r_alarm <= 1'b0;
      end
      if (bus.sample_valid && !r_ready && (r_drop != DROP_MAX)) begin
        r_drop <= r_drop + DROP_W'(1);
      end
    end
  end

`ifndef TEMP_ALARM_LATCH_EN
  logic w_unused_clr;
  assign w_unused_clr = bus.alarm_clr;
`endif

  assign bus.sample_ready = r_ready;
  assign bus.avg_out      = w_avg;
  assign bus.avg_valid    = w_avg_valid;
  assign bus.alarm        = r_alarm;
  assign bus.alarm_rise   = r_alarm_rise;
  assign bus.drop_cnt     = r_drop;

endmodule

// File: tb/tb_temp_threshold_monitor.sv
// Bench for temp_threshold_monitor: block table, hand-written corner sequences and random traffic
// checked cycle by cycle against a queue-based reference model.
module tb_temp_threshold_monitor;
  import temp_pkg::*;

  localparam int AVG_LOG2 = 3;
  localparam int NS       = 1 << AVG_LOG2;
  localparam int TH_H     = 37;
  localparam int TH_L     = 33;
`ifdef TEMP_ALARM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstc;
  always #5 clk = ~clk;

  temp_threshold_monitor_if #(.DW(DATA_W)) bus ();

  temp_threshold_monitor #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2),
    .TH_HIGH  (10'd37),
    .TH_LOW   (10'd33)
  ) dut (
    .clk  (clk),
    .rstc (rstc),
    .bus  (bus)
  );

  int n_vec;
  int n_err;

  // Reference model state
  int m_t;
  int m_avg;
  int m_drop;
  int m_alarm_edge;
  int m_ready_edge;
  bit m_ready;
  bit m_avg_valid;
  bit m_alarm;
  bit m_rise;
  int m_q[$];

  typedef struct {
    logic [9:0] val;
    int         exp_avg;
    bit         exp_alarm_hyst;
    bit         exp_alarm_latch;
  } blk_vec_t;

  blk_vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, m_t);
    end
  endtask

  task automatic model_edge(input logic v, input logic [9:0] s, input logic clr, input logic rst);
    int sum;
    m_t++;
    if (rst) begin
      m_q.delete();
      m_avg = 0; m_avg_valid = 0; m_alarm = 0; m_rise = 0; m_drop = 0;
      m_ready = 1; m_alarm_edge = -1; m_ready_edge = -1;
    end else begin
      m_avg_valid = 0;
      m_rise      = 0;
      if (v && !m_ready) begin
        if (m_drop < 255) m_drop++;
      end else if (v) begin
        m_q.push_back(int'(s));
        if (m_q.size() == NS) begin
          sum = 0;
          foreach (m_q[k]) sum += m_q[k];
          m_avg = sum / NS;
          m_avg_valid = 1;
          m_q.delete();
          m_ready = 0;
          m_alarm_edge = m_t + 1;
          m_ready_edge = m_t + 2;
        end
      end
      if (m_t == m_alarm_edge) begin
        if (!m_alarm && m_avg > TH_H) begin
          m_alarm = 1;
          m_rise  = 1;
        end else if (!LATCH && m_alarm && m_avg < TH_L) begin
          m_alarm = 0;
        end
      end
      if (LATCH && clr && !m_rise) m_alarm = 0;
      if (m_t == m_ready_edge) m_ready = 1;
    end
  endtask

  // One clock: drive at the negedge, let the posedge act, compare at the next negedge.
  task automatic cycle(input logic v, input logic [9:0] s, input logic clr, input logic rst);
    bus.sample_valid = v;
    bus.sample_in    = s;
    bus.alarm_clr    = clr;
    rstc             = rst;
    model_edge(v, s, clr, rst);
    @(posedge clk);
    @(negedge clk);
    chk("sample_ready", 32'(bus.sample_ready), 32'(m_ready));
    chk("avg_out",      32'(bus.avg_out),      32'(m_avg));
    chk("avg_valid",    32'(bus.avg_valid),    32'(m_avg_valid));
    chk("alarm",        32'(bus.alarm),        32'(m_alarm));
    chk("alarm_rise",   32'(bus.alarm_rise),   32'(m_rise));
    chk("drop_cnt",     32'(bus.drop_cnt),     32'(m_drop));
  endtask

  task automatic send_block(input logic [9:0] v);
    for (int i = 0; i < NS; i++) cycle(1'b1, v, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 10'd0, 1'b0, 1'b0);
  endtask

  logic [9:0] trunc_s [8];
  logic       rv;
  logic [9:0] rs;
  logic       rclr;
  logic       rrst;
  int         sel;

  initial begin
    n_vec = 0; n_err = 0;
    m_t = 0; m_q.delete();
    m_avg = 0; m_avg_valid = 0; m_alarm = 0; m_rise = 0; m_drop = 0;
    m_ready = 1; m_alarm_edge = -1; m_ready_edge = -1;
    bus.sample_valid = 1'b0; bus.sample_in = 10'd0; bus.alarm_clr = 1'b0; rstc = 1'b1;

    tbl[0] = '{10'd40,   40,   1'b1, 1'b1};
    tbl[1] = '{10'd35,   35,   1'b1, 1'b1};
    tbl[2] = '{10'd32,   32,   1'b0, 1'b1};
    tbl[3] = '{10'd37,   37,   1'b0, 1'b1};
    tbl[4] = '{10'd38,   38,   1'b1, 1'b1};
    tbl[5] = '{10'd33,   33,   1'b1, 1'b1};
    tbl[6] = '{10'd1023, 1023, 1'b1, 1'b1};
    tbl[7] = '{10'd0,    0,    1'b0, 1'b1};
    trunc_s = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd9};

    @(negedge clk);

    // Reset state and first-block latency with 8x40
    cycle(1'b0, 10'd0, 1'b0, 1'b1);
    chk("rst_ready", 32'(bus.sample_ready), 32'd1);
    chk("rst_alarm", 32'(bus.alarm), 32'd0);
    chk("rst_drop",  32'(bus.drop_cnt), 32'd0);
    for (int i = 0; i < NS; i++) cycle(1'b1, 10'd40, 1'b0, 1'b0);
    chk("t1_valid_n1", 32'(bus.avg_valid), 32'd1);
    chk("t1_avg_n1",   32'(bus.avg_out), 32'd40);
    chk("t1_alarm_n1", 32'(bus.alarm), 32'd0);
    chk("t1_ready_n1", 32'(bus.sample_ready), 32'd0);
    cycle(1'b0, 10'd0, 1'b0, 1'b0);
    chk("t1_alarm_n2", 32'(bus.alarm), 32'd1);
    chk("t1_rise_n2",  32'(bus.alarm_rise), 32'd1);
    chk("t1_ready_n2", 32'(bus.sample_ready), 32'd0);
    cycle(1'b0, 10'd0, 1'b0, 1'b0);
    chk("t1_ready_n3", 32'(bus.sample_ready), 32'd1);
    chk("t1_rise_n3",  32'(bus.alarm_rise), 32'd0);

    // Table of whole blocks from a fresh reset
    cycle(1'b0, 10'd0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send_block(tbl[i].val);
      chk("tbl_avg",   32'(bus.avg_out), 32'(tbl[i].exp_avg));
      chk("tbl_alarm", 32'(bus.alarm),
          32'(LATCH ? tbl[i].exp_alarm_latch : tbl[i].exp_alarm_hyst));
    end

    // Truncating divide: sum 37 over 8 samples
    cycle(1'b0, 10'd0, 1'b0, 1'b1);
    for (int i = 0; i < NS; i++) cycle(1'b1, trunc_s[i], 1'b0, 1'b0);
    chk("trunc_avg", 32'(bus.avg_out), 32'd4);
    for (int i = 0; i < 3; i++) cycle(1'b0, 10'd0, 1'b0, 1'b0);

    // Continuous valid: two drops per block, then saturation
    cycle(1'b0, 10'd0, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) cycle(1'b1, 10'd7, 1'b0, 1'b0);
    chk("drop_3blk", 32'(bus.drop_cnt), 32'd6);
    for (int i = 0; i < 1500; i++) cycle(1'b1, 10'd7, 1'b0, 1'b0);
    chk("drop_sat", 32'(bus.drop_cnt), 32'd255);

    // Reset coinciding with a would-be drop
    for (int i = 0; i < NS; i++) cycle(1'b1, 10'd7, 1'b0, 1'b0);
    cycle(1'b1, 10'd7, 1'b0, 1'b1);
    chk("rstdrop_cnt",   32'(bus.drop_cnt), 32'd0);
    chk("rstdrop_valid", 32'(bus.avg_valid), 32'd0);

    // Reset mid-block discards the partial sum
    for (int i = 0; i < 5; i++) cycle(1'b1, 10'd60, 1'b0, 1'b0);
    cycle(1'b0, 10'd0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 10'd0, 1'b0, 1'b0);
      chk("midrst_novalid", 32'(bus.avg_valid), 32'd0);
    end
    send_block(10'd20);
    chk("midrst_avg", 32'(bus.avg_out), 32'd20);

    // alarm_clr behaviour
    cycle(1'b0, 10'd0, 1'b0, 1'b1);
    send_block(10'd40);
    chk("clr_set", 32'(bus.alarm), 32'd1);
    send_block(10'd10);
    chk("clr_after_low", 32'(bus.alarm), 32'(LATCH ? 1 : 0));
    cycle(1'b0, 10'd0, 1'b1, 1'b0);
    chk("clr_pulse", 32'(bus.alarm), 32'd0);
    for (int i = 0; i < NS; i++) cycle(1'b1, 10'd40, 1'b0, 1'b0);
    cycle(1'b0, 10'd0, 1'b1, 1'b0);
    chk("clr_vs_set_alarm", 32'(bus.alarm), 32'd1);
    chk("clr_vs_set_rise",  32'(bus.alarm_rise), 32'd1);
    cycle(1'b0, 10'd0, 1'b0, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rv   = ($urandom_range(0, 9) < 7);
      sel  = int'($urandom_range(0, 9));
      rs   = (sel < 8) ? 10'($urandom_range(25, 45)) : 10'($urandom_range(0, 1023));
      rclr = ($urandom_range(0, 30) == 0);
      rrst = ($urandom_range(0, 250) == 0);
      cycle(rv, rs, rclr, rrst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
